ft245_fifo_responder: RTL

- Synthesizable device-side responder for the FT245/UM245R-style parallel FIFO bus driven by the CPU (D, WR, _RD, _TXE, _RXF).
- Holds two byte FIFOs:
  - RXQ: bytes waiting for the CPU to read. Filled from the host-side in_* stream.
  - TXQ: bytes the CPU has written. Drained to the host-side out_* stream.
- All bus inputs are asynchronous to clk and are synchronized internally.
- Replaces the behavioural um245r model wherever a clocked, implementable endpoint is needed.

---
 rtl/ft245_fifo_responder_if.sv | 25 ++
 rtl/ft245_fifo_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ft245_fifo_responder_if.sv
// rtl/ft245_fifo_responder_if.sv - CPU strobes, host byte streams and status flags of the FT245 responder
interface ft245_fifo_responder_if;
  logic       WR;
  logic       _RD;
  logic       _TXE;
  logic       _RXF;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic       underflow;

  modport master (
    output WR, _RD, in_data, in_valid, out_ready,
    input  _TXE, _RXF, in_ready, out_data, out_valid, overflow, underflow
  );

  modport slave (
    input  WR, _RD, in_data, in_valid, out_ready,
    output _TXE, _RXF, in_ready, out_data, out_valid, overflow, underflow
  );
endinterface

// File: rtl/ft245_fifo_responder.sv
// rtl/ft245_fifo_responder.sv - clocked FT245-style CPU FIFO endpoint with RX/TX byte queues
// Define FT245_RESPONDER_LOOPBACK_EN to route CPU writes back into the read queue.
module ft245_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       mr,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);
  logic [7:0]            mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;

  assign empty = (count == '0);
  assign full  = count[DEPTH_LOG2];
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ft245_fifo_responder #(
  parameter int DEPTH_LOG2  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  mr,
  inout  wire [7:0]             D,
  ft245_fifo_responder_if.slave bus
);
  typedef enum logic       {W_IDLE, W_BUSY} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_RECOVER} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [SYNC_STAGES-1:0] wr_sync, rd_sync;
  logic [7:0]             d_sync [SYNC_STAGES];
  logic                   wr_dly, rd_dly;
  logic                   wr_s, rd_s, wr_fall, rd_fall, rd_rise;
  logic [7:0]             d_s, rd_hold;
  logic                   rd_was_empty, txe_q, rxf_q, overflow_q, underflow_q;
  logic                   rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0]             rx_head, rx_push_data;
  logic                   wr_take, wr_target_full;

  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign rd_s    = rd_sync[SYNC_STAGES-1];
  assign d_s     = d_sync[SYNC_STAGES-1];
  assign wr_fall = wr_dly & ~wr_s;
  assign rd_fall = rd_dly & ~rd_s;
  assign rd_rise = ~rd_dly & rd_s;
  assign wr_take = (w_state == W_IDLE) & wr_fall;
  assign rx_pop  = (r_state == R_ACTIVE) & rd_rise & ~rd_was_empty;

  // Drive follows the raw strobe so the CPU sees data without clock latency.
  assign D = (!bus._RD && !mr) ? rd_hold : 8'hzz;

  assign bus._TXE      = txe_q;
  assign bus._RXF      = rxf_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      wr_sync <= '1;
      rd_sync <= '1;
      wr_dly  <= 1'b1;
      rd_dly  <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) d_sync[i] <= '0;
    end else begin
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], bus.WR};
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], bus._RD};
      wr_dly    <= wr_s;
      rd_dly    <= rd_s;
      d_sync[0] <= D;
      for (int i = 1; i < SYNC_STAGES; i++) d_sync[i] <= d_sync[i-1];
    end
  end

`ifdef FT245_RESPONDER_LOOPBACK_EN
  wire unused_host = bus.out_ready ^ bus.in_valid ^ (^bus.in_data);

  assign wr_target_full = rx_full;
  assign rx_push        = wr_take & ~rx_full;
  assign rx_push_data   = d_s;
  assign bus.in_ready   = 1'b0;
  assign bus.out_valid  = 1'b0;
  assign bus.out_data   = 8'h00;
`else
  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0] tx_head;

  assign wr_target_full = tx_full;
  assign tx_push        = wr_take & ~tx_full;
  assign tx_pop         = bus.out_valid & bus.out_ready;
  assign bus.in_ready   = ~mr & ~rx_full;
  assign rx_push        = bus.in_valid & bus.in_ready;
  assign rx_push_data   = bus.in_data;
  assign bus.out_valid  = ~tx_empty;
  assign bus.out_data   = tx_empty ? 8'h00 : tx_head;

  ft245_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_txq (
    .clk(clk), .mr(mr), .push(tx_push), .push_data(d_s), .pop(tx_pop),
    .head(tx_head), .empty(tx_empty), .full(tx_full)
  );
`endif

  ft245_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rxq (
    .clk(clk), .mr(mr), .push(rx_push), .push_data(rx_push_data), .pop(rx_pop),
    .head(rx_head), .empty(rx_empty), .full(rx_full)
  );

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      w_state    <= W_IDLE;
      overflow_q <= 1'b0;
      txe_q      <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (wr_fall) begin
          w_state <= W_BUSY;
          if (wr_target_full) overflow_q <= 1'b1;
        end
        W_BUSY:  if (wr_s) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
      txe_q <= (w_state == W_BUSY) | wr_target_full;
    end
  end

  // rd_hold keeps its last value on an empty queue so an underflow read is stable.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      r_state      <= R_IDLE;
      rd_hold      <= 8'h00;
      rd_was_empty <= 1'b0;
      underflow_q  <= 1'b0;
      rxf_q        <= 1'b1;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (!rx_empty) rd_hold <= rx_head;
          if (rd_fall) begin
            r_state      <= R_ACTIVE;
            rd_was_empty <= rx_empty;
            if (rx_empty) underflow_q <= 1'b1;
          end
        end
        R_ACTIVE:  if (rd_rise) r_state <= R_RECOVER;
        R_RECOVER: r_state <= R_IDLE;
        default:   r_state <= R_IDLE;
      endcase
      rxf_q <= rx_empty | (r_state != R_IDLE);
    end
  end
endmodule
